cipher_block_sequencer: RTL



---
 rtl/cipher_block_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cipher_block_sequencer.sv
// cipher_block_sequencer: packs 8 ROM bytes per block, passes each block through the cipher core, unpacks the result into RAM.
// Optional SEQ_BYPASS_EN adds a bypass input that copies ROM blocks straight to RAM without the core.
module cipher_block_sequencer #(
    parameter int ADDR_W    = 15,
    parameter int IMG_BYTES = 19200,
    parameter int ROM_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [63:0]       blk_out,
    output logic              blk_out_valid,
    input  logic              blk_out_ready,
    input  logic [63:0]       blk_in,
    input  logic              blk_in_valid,
    output logic              blk_in_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
`ifdef SEQ_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WRITE, DONE} state_t;
    // One extra address bit keeps base+k comparisons exact when IMG_BYTES == 2**ADDR_W.
    localparam logic [ADDR_W:0] IMG = (ADDR_W+1)'(IMG_BYTES);
    localparam logic [3:0] LAT = 4'(ROM_LAT);
    state_t state;
    logic [ADDR_W-1:0] base;
    logic [3:0] cnt;
    logic [63:0] wblk, src;
    logic [ADDR_W:0] base_x, nxt, cap;
    logic skip, load;
`ifdef SEQ_BYPASS_EN
    assign skip = bypass;
`else
    assign skip = 1'b0;
`endif
    assign base_x = {1'b0, base};
    assign nxt = base_x + {{(ADDR_W-3){1'b0}}, cnt + 4'd1};
    assign cap = base_x + {{(ADDR_W-3){1'b0}}, cnt - LAT};
    assign src = (state == WAIT) ? blk_in : blk_out;
    assign load = (state == WAIT) ? blk_in_valid : (state == ISSUE && skip);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            base <= '0;
            cnt <= '0;
            wblk <= '0;
            rd_addr <= '0;
            blk_out <= '0;
            blk_out_valid <= 1'b0;
            blk_in_ready <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_en <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= FETCH;
                    base <= '0;
                    cnt <= '0;
                    rd_addr <= '0;
                    busy <= 1'b1;
                    done <= 1'b0;
                end
                FETCH: begin
                    cnt <= cnt + 4'd1;
                    if (cnt < 4'd7 && nxt < IMG) rd_addr <= nxt[ADDR_W-1:0];
                    if (cnt >= LAT) blk_out <= {blk_out[55:0], (cap < IMG) ? rd_data : 8'h00};
                    if (cnt == LAT + 4'd7) state <= ISSUE;
                end
                ISSUE: if (!skip) begin
                    if (!blk_out_valid) blk_out_valid <= 1'b1;
                    else if (blk_out_ready) begin
                        blk_out_valid <= 1'b0;
                        blk_in_ready <= 1'b1;
                        state <= WAIT;
                    end
                end
                WRITE: begin
                    cnt <= cnt + 4'd1;
                    wr_addr <= nxt[ADDR_W-1:0];
                    wr_data <= wblk[63:56];
                    wblk <= {wblk[55:0], 8'h00};
                    wr_en <= cnt < 4'd7 && nxt < IMG;
                    if (cnt == 4'd7) begin
                        cnt <= '0;
                        if (nxt >= IMG) begin
                            state <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            state <= FETCH;
                            base <= nxt[ADDR_W-1:0];
                            rd_addr <= nxt[ADDR_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
            // Entering WRITE (core result or bypassed block) overrides the per-state updates above.
            if (load) begin
                state <= WRITE;
                cnt <= '0;
                wr_en <= 1'b1;
                wr_addr <= base;
                wr_data <= src[63:56];
                wblk <= {src[55:0], 8'h00};
                blk_in_ready <= 1'b0;
                blk_out_valid <= 1'b0;
            end
        end
    end
endmodule
